// File: rtl/quad_pkg.sv
// Shared definitions for the quadcopter command path.
// Contents: opcode constants, positive-acknowledge byte, frame-state enum,
// and the packed command/data payload held by the frame receiver.
package quad_pkg;

  // Opcodes carried in the first byte of a command frame
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  // Positive acknowledge response byte
  localparam logic [7:0] POS_ACK = 8'hA5;

  // Position within a 3-byte command frame
  typedef enum logic [1:0] {
    CMD  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } frame_state_e;

  // Decoded frame payload presented to the command configuration unit
  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] data;
  } cmd_frame_t;

endpackage

// File: rtl/uart_comm_if.sv
// Command/response handshake between uart_comm and the command unit.
// slave  : uart_comm side (drives cmd_rdy, cmd, data, resp_sent)
// master : command-unit side (drives clr_cmd_rdy, resp, send_resp)
interface uart_comm_if;

  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    input  cmd_rdy, cmd, data, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    output cmd_rdy, cmd, data, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

endinterface

// File: rtl/uart_xcvr.sv
// 8N1 UART transceiver with independent RX and TX engines.
// Ports: clk, rst_n; RX (async serial in), TX (serial out);
//        rx_rdy/rx_byte (one-cycle pulse per good byte);
//        trmt/tx_data (start a transmission), tx_done (pulse at end of stop
//        bit), tx_busy (frame in progress).
module uart_xcvr
  import quad_pkg::*;
#(
  parameter int unsigned BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  output logic [7:0] rx_byte,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam int unsigned CNT_W = $clog2(BAUD_CNT);
  // First sample lands BAUD_CNT/2 clocks after the synchronized edge; two of
  // those clocks are spent detecting the edge and loading the counter.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_CNT / 2 - 2);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_CNT - 1);
  localparam logic [3:0]       LAST_BIT  = 4'd9;

  // ---------------- RX engine ----------------
  logic [2:0]       rx_sync_q, rx_sync_d;
  logic             rx_busy_q, rx_busy_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_rdy_q, rx_rdy_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_line, rx_prev;

  // [0],[1] form the synchronizer; [2] is the previous synchronized value
  assign rx_line = rx_sync_q[1];
  assign rx_prev = rx_sync_q[2];

  // Bit index 0 = start, 1..8 = data LSB first, 9 = stop
  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], RX};
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_rdy_d   = 1'b0;
    rx_byte_d  = rx_byte_q;
    if (!rx_busy_q) begin
      if (rx_prev && !rx_line) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = HALF_LOAD;
        rx_bit_d  = 4'd0;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - CNT_W'(1);
    end else begin
      rx_cnt_d = FULL_LOAD;
      if (rx_bit_q == LAST_BIT) begin
        rx_busy_d = 1'b0;
        if (rx_line) begin
          rx_rdy_d  = 1'b1;
          rx_byte_d = rx_shift_q;
        end
      end else begin
        if (rx_bit_q != 4'd0) rx_shift_d = {rx_line, rx_shift_q[7:1]};
        rx_bit_d = rx_bit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= 3'b111;
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      rx_rdy_q   <= 1'b0;
      rx_byte_q  <= 8'h00;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_busy_q  <= rx_busy_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  assign rx_rdy  = rx_rdy_q;
  assign rx_byte = rx_byte_q;

  // ---------------- TX engine ----------------
  logic             tx_q, tx_d;
  logic             tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic             tx_done_q, tx_done_d;

  // The start bit goes straight to the line register; the shifter holds the
  // remaining data bits plus stop bit.
  always_comb begin
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_d  = 1'b1;
        tx_d       = 1'b0;
        tx_shift_d = {1'b1, tx_data};
        tx_cnt_d   = FULL_LOAD;
        tx_bit_d   = 4'd0;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - CNT_W'(1);
    end else begin
      tx_cnt_d = FULL_LOAD;
      if (tx_bit_q == LAST_BIT) begin
        tx_busy_d = 1'b0;
        tx_d      = 1'b1;
        tx_done_d = 1'b1;
      end else begin
        tx_d       = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= 9'h1FF;
      tx_done_q  <= 1'b0;
    end else begin
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = tx_q;
  assign tx_done = tx_done_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: rtl/uart_comm.sv
// Serial front end: assembles 3-byte command frames from RX into cmd/data
// with a cmd_rdy flag, and sends the requested response byte on TX.
// Ports: clk, rst_n; RX, TX (serial pins);
//        bus (slave): cmd_rdy, cmd, data, clr_cmd_rdy, resp, send_resp,
//        resp_sent.
module uart_comm
  import quad_pkg::*;
#(
  parameter int unsigned BAUD_CNT = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  uart_comm_if.slave  bus
);

  logic         rx_rdy;
  logic [7:0]   rx_byte;
  logic         tx_done;
  logic         tx_busy;

  logic         trmt_q, trmt_d;
  logic [7:0]   tx_data_q, tx_data_d;
  frame_state_e state_q, state_d;
  logic [7:0]   temp_q, temp_d;
  cmd_frame_t   frame_q, frame_d;
  logic         cmd_rdy_q, cmd_rdy_d;

  uart_xcvr #(.BAUD_CNT(BAUD_CNT)) u_xcvr (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .rx_rdy  (rx_rdy),
    .rx_byte (rx_byte),
    .trmt    (trmt_q),
    .tx_data (tx_data_q),
    .tx_done (tx_done),
    .tx_busy (tx_busy)
  );

  // Frame assembly; a set of cmd_rdy overrides a same-cycle clear
  always_comb begin
    state_d   = state_q;
    temp_d    = temp_q;
    frame_d   = frame_q;
    cmd_rdy_d = cmd_rdy_q;
    if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (rx_rdy) begin
      case (state_q)
        CMD: begin
          frame_d.cmd = rx_byte;
          cmd_rdy_d   = 1'b0;
          state_d     = HIGH;
        end
        HIGH: begin
          temp_d  = rx_byte;
          state_d = LOW;
        end
        LOW: begin
          frame_d.data = {temp_q, rx_byte};
          cmd_rdy_d    = 1'b1;
          state_d      = CMD;
        end
        default: state_d = CMD;
      endcase
    end
  end

  // Response request capture; requests while the transmitter is busy drop
  always_comb begin
    trmt_d    = bus.send_resp & ~tx_busy;
    tx_data_d = trmt_d ? bus.resp : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CMD;
      temp_q    <= 8'h00;
      frame_q   <= '0;
      cmd_rdy_q <= 1'b0;
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      temp_q    <= temp_d;
      frame_q   <= frame_d;
      cmd_rdy_q <= cmd_rdy_d;
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.cmd       = frame_q.cmd;
  assign bus.data      = frame_q.data;
  assign bus.resp_sent = tx_done;

endmodule

// File: tb/tb_uart_comm.sv
module tb_uart_comm;

  localparam int BAUD = 16;
  // Edges from the RX start-bit fall until cmd/data/cmd_rdy reflect the byte:
  // 2 synchronizer + BAUD/2 + 9*BAUD to rx_rdy, then one more for the frame regs
  localparam int RX_LAT = 2 + BAUD / 2 + 9 * BAUD + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;

  uart_comm_if bus ();

  uart_comm #(.BAUD_CNT(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .TX    (tx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          ev_edge[$];
  logic [7:0]  ev_byte[$];
  int          m_pos = 0;
  logic [7:0]  m_cmd = 8'h00;
  logic [7:0]  m_hi = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_rdy = 1'b0;
  int          tx_start = -1;
  int          tx_end = -1;
  logic [9:0]  tx_word = 10'h3FF;
  logic [7:0]  m_b;
  logic        m_set, m_clr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_cmd = 8'h00; m_hi = 8'h00; m_data = 16'h0000; m_rdy = 1'b0;
      ev_edge.delete(); ev_byte.delete();
      tx_start = -1; tx_end = -1;
    end else begin
      cyc++;
      m_set = 1'b0;
      m_clr = bus.clr_cmd_rdy;
      if (ev_edge.size() > 0 && ev_edge[0] == cyc) begin
        m_b = ev_byte.pop_front();
        void'(ev_edge.pop_front());
        if (m_pos == 0) begin
          m_cmd = m_b; m_clr = 1'b1; m_pos = 1;
        end else if (m_pos == 1) begin
          m_hi = m_b; m_pos = 2;
        end else begin
          m_data = {m_hi, m_b}; m_set = 1'b1; m_pos = 0;
        end
      end
      if (m_set) m_rdy = 1'b1;
      else if (m_clr) m_rdy = 1'b0;
      if (bus.send_resp && cyc > tx_end) begin
        tx_start = cyc + 1;
        tx_end   = tx_start + 10 * BAUD;
        tx_word  = {1'b1, bus.resp, 1'b0};
      end
    end
  end

  logic exp_tx;
  always @(negedge clk) begin
    if (cmp_en) begin
      if (tx_start >= 0 && cyc >= tx_start && cyc < tx_end) exp_tx = tx_word[(cyc - tx_start) / BAUD];
      else exp_tx = 1'b1;
      chk("TX", 32'(tx), 32'(exp_tx));
      chk("resp_sent", 32'(bus.resp_sent), 32'(tx_end >= 0 && cyc == tx_end));
      chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
      chk("cmd", 32'(bus.cmd), 32'(m_cmd));
      chk("data", 32'(bus.data), 32'(m_data));
    end
  end

  // ---------------- stimulus helpers ----------------
  int last_ev = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    step();
    last_ev = cyc + RX_LAT;
    if (stop) begin
      ev_edge.push_back(last_ev);
      ev_byte.push_back(b);
    end
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (BAUD) step();
    end
    rx = 1'b1;
    repeat (4) step();
  endtask

  task automatic clr_pulse();
    step();
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic rdy, input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.cmd_rdy), 32'(rdy));
    chk({tag, "_cmd"}, 32'(bus.cmd), 32'(c));
    chk({tag, "_data"}, 32'(bus.data), 32'(d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  int         ns, t_fall, t_done, n_extra;
  logic [9:0] tx_bits;

  initial begin
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp        = 8'h00;
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("rst_cmd", 32'(bus.cmd), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_resp_sent", 32'(bus.resp_sent), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (5) step();

    // Basic frame then clear
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    chk_frame("f1", 1'b1, 8'h02, 16'h1234);
    clr_pulse();
    chk_frame("f1_clr", 1'b0, 8'h02, 16'h1234);

    // Response transmit, with an ignored second request mid-frame
    step();
    bus.resp = 8'hA5;
    bus.send_resp = 1'b1;
    step();
    ns = cyc;
    bus.send_resp = 1'b0;
    t_fall = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        t_fall = cyc;
        break;
      end
    end
    chk("tx_start_edge", 32'(t_fall), 32'(ns + 1));
    if (t_fall < 0) t_fall = ns + 1;
    for (int i = 0; i < 10; i++) begin
      while (cyc < t_fall + BAUD * i + BAUD / 2) @(negedge clk);
      tx_bits[i] = tx;
      if (i == 4) begin
        step();
        bus.send_resp = 1'b1;
        step();
        bus.send_resp = 1'b0;
      end
    end
    chk("tx_frame", 32'(tx_bits), 32'(10'b1101001010));
    t_done = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.resp_sent) begin
        t_done = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("resp_sent_lat", 32'(t_done - t_fall), 32'd160);
    n_extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.resp_sent) n_extra++;
    end
    chk("resp_sent_extra", 32'(n_extra), 32'd0);

    // New opcode without clear drops cmd_rdy
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk_frame("f2", 1'b1, 8'h05, 16'h00FF);
    send_byte(8'h06, 1'b1);
    chk_frame("f3_op", 1'b0, 8'h06, 16'h00FF);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    chk_frame("f3", 1'b1, 8'h06, 16'hABCD);

    // Framing error inside a frame is discarded
    clr_pulse();
    send_byte(8'h03, 1'b1);
    send_byte(8'h77, 1'b0);
    chk_frame("f4_bad", 1'b0, 8'h03, 16'hABCD);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk_frame("f4", 1'b1, 8'h03, 16'h1122);

    // Reset midway through the second byte
    send_byte(8'h09, 1'b1);
    step();
    rx = 1'b0;
    repeat (BAUD * 4) step();
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("mid_rst_cmd", 32'(bus.cmd), 32'd0);
    chk("mid_rst_data", 32'(bus.data), 32'd0);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    send_byte(8'h04, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFE, 1'b1);
    chk_frame("f5", 1'b1, 8'h04, 16'hFFFE);

    // Clear coinciding with frame completion: set wins
    clr_pulse();
    send_byte(8'h08, 1'b1);
    send_byte(8'h5A, 1'b1);
    fork
      send_byte(8'hC3, 1'b1);
      begin
        step();
        step();
        wait_edge(last_ev - 1);
        bus.clr_cmd_rdy = 1'b1;
        wait_edge(last_ev);
        bus.clr_cmd_rdy = 1'b0;
        @(negedge clk);
        chk("set_wins", 32'(bus.cmd_rdy), 32'd1);
      end
    join
    chk_frame("f6", 1'b1, 8'h08, 16'h5AC3);

    repeat (4) step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_comm.md
# uart_comm

Quadcopter-side serial front end. Receives 3-byte command frames (opcode, data high, data low) on the RX pin and presents them to the command configuration unit as `cmd`/`data` with a `cmd_rdy` flag. Transmits the single response byte that the unit requests via `send_resp` on the TX pin. Contains the 8N1 UART transceiver; the only external pins are RX and TX.

## Interface
- `BAUD_CNT`, default 2604: clocks per bit (50 MHz / 19200 baud); must be ≥ 4.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `RX`  in  1  serial input; asynchronous, idles high
- `TX`  out  1  serial output; idles high
- `cmd_rdy`  out  1  a complete frame is held in `cmd`/`data`
- `cmd`  out  8  opcode byte (first byte of the frame)
- `data`  out  16  `{second byte, third byte}`
- `clr_cmd_rdy`  in  1  consumer has digested the frame; clears `cmd_rdy`
- `resp`  in  8  response byte to send (normally 0xA5)
- `send_resp`  in  1  one-cycle pulse; start transmitting `resp`
- `resp_sent`  out  1  one-cycle pulse when the response stop bit completes

## Operation
- Reset values: `cmd_rdy`=0, `cmd`=0x00, `data`=0x0000, `TX`=1, `resp_sent`=0, frame FSM in `CMD`, RX and TX engines idle.
- RX engine:
  - `RX` passes through a 2-flop synchronizer.
  - A start bit is detected on a 1→0 transition while the engine is idle.
  - Each bit is sampled at its midpoint: the first sample is taken `BAUD_CNT/2` clocks after the falling edge, and subsequent samples every `BAUD_CNT` clocks.
  - Data is received LSB first.
  - The stop bit is sampled. If it is 0, the byte is discarded and no `rx_rdy` is produced. If it is 1, `rx_rdy` pulses for one cycle with `rx_byte`.
  - The engine returns to idle right after the stop-bit sample.
- Frame FSM (advances only on `rx_rdy`):
  - `CMD`: latch `cmd`, go to `HIGH`.
  - `HIGH`: hold the byte in a temporary register, go to `LOW`.
  - `LOW`: load `data` with `{temp, rx_byte}`, set `cmd_rdy`, go to `CMD`.
- Clearing `cmd_rdy`:
  - `clr_cmd_rdy` clears it.
  - `rx_rdy` in state `CMD` also clears it, because a new frame overwrites the old one.
  - If set and clear occur in the same cycle, set wins.
- `cmd`/`data` are held stable while `cmd_rdy`=1, except that a new opcode byte overwrites `cmd`.
- No inter-byte timeout. Framing errors do not advance the FSM.
- TX engine:
  - When idle, `send_resp` loads `{1, resp, 0}` into a 10-bit shift register, and the frame is shifted out LSB first, `BAUD_CNT` clocks per bit.
  - `send_resp` while busy is ignored.
  - After the 10th bit period: `resp_sent` pulses, `TX`=1, engine idle.
- RX and TX are fully independent; full-duplex operation is allowed.

## Timing
- Start bit on `RX` appears on `TX`... (n/a). RX latency: `rx_rdy` fires 2 cycles (synchronizer) + `BAUD_CNT/2` + 9·`BAUD_CNT` clocks after the falling edge of the start bit.
- `cmd_rdy` rises 1 cycle after `rx_rdy` of the third byte.
- `clr_cmd_rdy` sampled high at edge N → `cmd_rdy` low after edge N.
- `TX` drives the start bit 1 cycle after the `send_resp` edge.
- `resp_sent` pulses exactly 10·`BAUD_CNT` cycles after `TX` falls.
- Baud counters reload on every bit boundary; there is no cumulative drift.
- Reset asserted mid-frame: both engines and the FSM return to reset values immediately. A partially received frame is lost, and a byte already on the wire is then ignored until the next idle-high → low transition.

## Structure
- Shared package `quad_pkg`:
  - opcode constants `SET_PTCH`=0x02 … `MTRS_OFF`=0x08
  - `POS_ACK`=0xA5
  - frame-state enum `{CMD, HIGH, LOW}`
- Sub-module `uart_xcvr` (parameter `BAUD_CNT`): RX/TX engines with byte interface `rx_rdy`, `rx_byte`, `trmt`, `tx_data`, `tx_done`, `tx_busy`.
- `uart_comm` contains the frame FSM, the temporary register, `cmd`/`data`/`cmd_rdy` registers, and the `send_resp`→`trmt` glue.

## Test plan
All scenarios use `BAUD_CNT`=16, with a bench-side UART model driving `RX` and checking `TX`.
- Send bytes 0x02, 0x12, 0x34 → `cmd_rdy`=1 with `cmd`=0x02, `data`=0x1234; `clr_cmd_rdy` pulse → `cmd_rdy`=0 next cycle, values held.
- Pulse `send_resp` with `resp`=0xA5 → `TX` carries start bit, 1,0,1,0,0,1,0,1, stop bit at 16 clocks/bit; `resp_sent` pulses once, exactly 160 cycles after `TX` falls. A second `send_resp` mid-frame has no effect.
- Frame 0x05,0x00,0xFF then 0x06 without clear → `cmd_rdy` drops when 0x06 is received; after 0xAB,0xCD it rises with `cmd`=0x06, `data`=0xABCD.
- Byte with stop bit forced 0 inside frame 0x03,[bad],0x11,0x22 → the bad byte is dropped; `data`=0x1122 after 0x11,0x22, `cmd`=0x03.
- Assert `rst_n` low midway through the second byte → all outputs at reset values. A following full frame 0x04,0xFF,0xFE is decoded correctly.
- `clr_cmd_rdy` held high in the same cycle the third byte completes → `cmd_rdy`=1 (set wins).
